// File: rtl/ring_rr_arbiter_pkg.sv
// ring_arb_pkg: shared types, default parameters and the ring-priority
// winner picker for ring_rr_arbiter.
//   first_from_ptr(req, ptr, n): one-hot winner among req[n-1:0], scanning
//   upward from the single set bit of ptr and wrapping n-1 -> 0.
package ring_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} arb_state_e;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 8;
  // Widest requester vector the picker handles; callers zero-extend into it.
  localparam int ARB_MAX_N        = 32;

  // Rotate req so the ptr position lands at bit 0, take the lowest set bit,
  // then rotate the winner back. Bits at or above n are ignored.
  function automatic logic [ARB_MAX_N-1:0] first_from_ptr(
    input logic [ARB_MAX_N-1:0] req,
    input logic [ARB_MAX_N-1:0] ptr,
    input int                   n
  );
    logic [ARB_MAX_N-1:0] rot;
    logic [ARB_MAX_N-1:0] win;
    logic                 found;
    int                   p;
    int                   idx;
    p = 0;
    for (int i = 0; i < ARB_MAX_N; i++)
      if (i < n && ptr[i]) p = i;
    rot = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      idx = (i + p < n) ? i + p : i + p - n;
      if (i < n) rot[i] = req[idx];
    end
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      idx = (i + p < n) ? i + p : i + p - n;
      if (i < n && rot[i] && !found) begin
        found    = 1'b1;
        win[idx] = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// ring_rr_arbiter_if: request/grant bundle between requesters and the arbiter.
//   req     requester -> arbiter, level request per requester
//   done    requester -> arbiter, owner releases the resource
//   gnt     arbiter -> requesters, one-hot registered grant
//   gnt_id  arbiter -> requesters, binary owner index (0 when idle)
//   busy    arbiter -> requesters, a grant is outstanding
//   timeout arbiter -> requesters, one-cycle forced-revocation pulse
interface ring_rr_arbiter_if
  import ring_arb_pkg::*;
#(
  parameter int N   = ARB_N_DEF,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (output req, done, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/ring_rr_arbiter_ptr.sv
// ring_rr_ptr: one-hot rotating-priority pointer, updated on the falling edge.
//   i_clk      clock (falling edge active)
//   i_rst_n    async active-low reset, loads bit 0
//   i_advance  load the pointer this edge
//   i_win      one-hot winner; pointer becomes winner rotated left by one
//   o_ptr      current one-hot pointer
module ring_rr_ptr #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_advance,
  input  logic [N-1:0] i_win,
  output logic [N-1:0] o_ptr
);
  logic [N-1:0] r_ptr;

  // i_win is one-hot whenever i_advance is set, so the ring stays one-hot.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ptr <= N'(1);
    else if (i_advance) r_ptr <= {i_win[N-2:0], i_win[N-1]};
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with one-hot ring pointer and optional
// hold timeout. All state moves on the falling edge of clk.
//   clk   clock (falling edge active)
//   ORI   async active-low reset
//   bus   slave side of ring_rr_arbiter_if (req/done in, gnt/gnt_id/busy/timeout out)
// N must not exceed ARB_MAX_N. MAX_HOLD = 0 disables the timeout.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
  parameter int IDW      = $clog2(N)
) (
  input logic              clk,
  input logic              ORI,
  ring_rr_arbiter_if.slave bus
);
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_e     r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [HCW-1:0] r_hold, w_hold_nxt;
  logic           r_timeout, w_timeout_nxt;
  logic [N-1:0]   w_ptr;
  logic [N-1:0]   w_win;
  logic           w_adv;
  logic           w_owner_req;
  logic           w_hold_max;
  logic [IDW-1:0] w_gnt_id;

  ring_rr_ptr #(.N(N)) u_ptr (
    .i_clk     (clk),
    .i_rst_n   (ORI),
    .i_advance (w_adv),
    .i_win     (w_win),
    .o_ptr     (w_ptr)
  );

  assign w_win       = N'(first_from_ptr(ARB_MAX_N'(bus.req), ARB_MAX_N'(w_ptr), N));
  assign w_owner_req = |(bus.req & r_gnt);
  assign w_hold_max  = (MAX_HOLD != 0) && (r_hold == HCW'(MAX_HOLD));

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    w_adv         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_win;
          w_hold_nxt  = HCW'(1);
          w_adv       = 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.done || !w_owner_req || w_hold_max) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
          w_hold_nxt    = '0;
          // Only flag revocation when the limit alone ended the grant.
          w_timeout_nxt = w_hold_max && !bus.done && w_owner_req;
        end else if (MAX_HOLD != 0) begin
          // Below the limit here, so incrementing cannot pass MAX_HOLD.
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge ORI) begin
    if (!ORI) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // gnt is one-hot or zero, so OR-ing indices gives the owner (0 when idle).
  always_comb begin
    w_gnt_id = '0;
    for (int k = 0; k < N; k++)
      if (r_gnt[k]) w_gnt_id = w_gnt_id | IDW'(k);
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = w_gnt_id;
  assign bus.busy    = (r_state == ST_GRANT);
  assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter (N=4, MAX_HOLD=8): integer-owner model compared
// every rising edge, plus hand-computed literal checks along a directed script.
module tb_ring_rr_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = 2;

  logic clk;
  logic ORI;
  int   n_chk = 0;
  int   n_err = 0;

  ring_rr_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  ring_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk (clk),
    .ORI (ORI),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: owner as an integer (-1 = none), priority start as an index.
  int   m_ptr   = 0;
  int   m_owner = -1;
  int   m_hold  = 0;
  logic m_to    = 1'b0;

  initial begin
    forever begin
      @(negedge clk or negedge ORI);
      if (!ORI) begin
        m_ptr = 0; m_owner = -1; m_hold = 0; m_to = 1'b0;
      end else begin
        m_to = 1'b0;
        if (m_owner < 0) begin
          for (int j = 0; j < N; j++) begin
            int k;
            k = (m_ptr + j) % N;
            if (m_owner < 0 && bus.req[k]) m_owner = k;
          end
          if (m_owner >= 0) begin
            m_hold = 1;
            m_ptr  = (m_owner + 1) % N;
          end
        end else begin
          logic oreq, lim;
          oreq = bus.req[m_owner];
          lim  = (MAX_HOLD != 0) && (m_hold >= MAX_HOLD);
          if (bus.done || !oreq || lim) begin
            m_to    = lim && !bus.done && oreq;
            m_owner = -1;
            m_hold  = 0;
          end else begin
            m_hold++;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      chk("cmp_gnt", 32'(bus.gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("cmp_gnt_id", 32'(bus.gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("cmp_busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("cmp_timeout", 32'(bus.timeout), 32'(m_to));
    end
  end

  // Inputs change 1 time unit after the rising edge; the DUT samples them at
  // the following falling edge and results are visible when tick returns.
  task automatic tick(input logic [N-1:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    bus.req  = '0;
    bus.done = 1'b0;
    ORI = 1'b1;
    #1 ORI = 1'b0;
    @(posedge clk); #1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    ORI = 1'b1;

    // Rotation with one IDLE cycle between grants.
    tick(4'b1111, 1'b0); chk("rot0", 32'(bus.gnt), 32'h1);
    tick(4'b1111, 1'b1); chk("rot0_rel", 32'(bus.gnt), 32'h0);
    tick(4'b1111, 1'b0); chk("rot1", 32'(bus.gnt), 32'h2);
    tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b0); chk("rot2", 32'(bus.gnt), 32'h4);
    tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b0); chk("rot3", 32'(bus.gnt), 32'h8);
    chk("rot3_id", 32'(bus.gnt_id), 32'd3);
    tick(4'b1111, 1'b1);
    tick(4'b1111, 1'b0); chk("rot_wrap", 32'(bus.gnt), 32'h1);
    tick(4'b1111, 1'b1);

    // Fairness skip: pointer at bit 1.
    tick(4'b1001, 1'b0); chk("skip_gnt", 32'(bus.gnt), 32'h8);
    chk("skip_id", 32'(bus.gnt_id), 32'd3);
    tick(4'b1001, 1'b1);
    tick(4'b1001, 1'b0); chk("skip_next", 32'(bus.gnt), 32'h1);
    tick(4'b1001, 1'b1);

    // done in IDLE is ignored; single-cycle request pulse.
    tick(4'b0000, 1'b1); chk("idle_done_busy", 32'(bus.busy), 32'h0);
    tick(4'b0000, 1'b1);
    tick(4'b0010, 1'b0); chk("pulse_gnt", 32'(bus.gnt), 32'h2);
    tick(4'b0000, 1'b0); chk("pulse_rel", 32'(bus.gnt), 32'h0);

    // Timeout after exactly MAX_HOLD cycles, then regrant.
    tick(4'b0100, 1'b0);
    cnt = (bus.gnt == 4'b0100) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick(4'b0100, 1'b0);
      if (bus.gnt == 4'b0100) cnt++;
      else break;
    end
    chk("to_len", 32'(cnt), 32'd8);
    chk("to_pulse", 32'(bus.timeout), 32'h1);
    chk("to_gnt0", 32'(bus.gnt), 32'h0);
    tick(4'b0100, 1'b0); chk("to_regrant", 32'(bus.gnt), 32'h4);
    chk("to_pulse_end", 32'(bus.timeout), 32'h0);

    // done coincides with the limit: plain release.
    repeat (7) tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b1);
    chk("done_lim_gnt", 32'(bus.gnt), 32'h0);
    chk("done_lim_to", 32'(bus.timeout), 32'h0);

    // Owner drops req without done.
    tick(4'b0100, 1'b0); chk("drop_gnt", 32'(bus.gnt), 32'h4);
    tick(4'b0000, 1'b0); chk("drop_rel", 32'(bus.gnt), 32'h0);
    chk("drop_to", 32'(bus.timeout), 32'h0);

    // Timed-out requester loses to another pending one.
    tick(4'b0010, 1'b0); chk("tr_gnt", 32'(bus.gnt), 32'h2);
    repeat (8) tick(4'b0010, 1'b0);
    chk("tr_pulse", 32'(bus.timeout), 32'h1);
    tick(4'b0110, 1'b0); chk("tr_other", 32'(bus.gnt), 32'h4);
    tick(4'b0110, 1'b1);

    // Async reset mid-grant.
    tick(4'b0100, 1'b0); chk("mr_gnt", 32'(bus.gnt), 32'h4);
    ORI = 1'b0;
    #1;
    chk("mr_gnt0", 32'(bus.gnt), 32'h0);
    chk("mr_busy", 32'(bus.busy), 32'h0);
    chk("mr_to", 32'(bus.timeout), 32'h0);
    bus.req = 4'b1111;
    @(posedge clk); #1;
    ORI = 1'b1;
    tick(4'b1111, 1'b0); chk("mr_first", 32'(bus.gnt), 32'h1);
    tick(4'b1111, 1'b1);
    tick(4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
